bram_rr_arbiter: RTL and testbench

//  N-requester, single-port BRAM arbiter. Parametrised successor to the fixed
//  CPU-cache/FIFO/DMA arbiter. Round-robin grant, one beat accepted per cycle,

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_rr_pick.sv | 28 ++
 rtl/bram_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_bram_rr_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the round-robin BRAM arbiter
package mem_arb_pkg;

  localparam int MAX_REQ  = 8;
  localparam int TAG_ID_W = 3;

  // One slot of the read-return pipeline; id wide enough for MAX_REQ requesters
  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rst_ptr(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// rtl/mem_arb_rr_pick.sv - combinational round-robin picker, searching upward from ptr+1
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any && req[(int'(ptr) + k) % NUM_REQ]) begin
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        id  = ID_W'((int'(ptr) + k) % NUM_REQ);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_rr_arbiter.sv
// rtl/bram_rr_arbiter.sv - N-port round-robin single-port BRAM arbiter with tagged read return
// Optional burst locking: define MEM_ARB_LOCK_EN.
module bram_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int AW        = 13,
  parameter int DW        = 32,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [NUM_REQ-1:0]    req_lock,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [AW-1:0]         bram_addr,
  output logic [DW-1:0]         bram_wdata,
  input  logic [DW-1:0]         bram_rdata
);

  localparam int              ID_W    = id_w(NUM_REQ);
  localparam logic [ID_W-1:0] RST_PTR = ID_W'(rst_ptr(NUM_REQ));

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gid;
  logic               xfer;
  logic               sel_wr;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;
  tag_t               tag_q [RD_LAT+1];

  mem_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .id    (pick_id),
    .any   (pick_any)
  );

`ifdef MEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic             lock_hold;
  logic [ID_W-1:0]  lock_id;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             use_lock;

  assign use_lock = lock_hold & req_valid[lock_id];
  assign cnt_next = use_lock ? burst_cnt + CNT_W'(1) : CNT_W'(1);
  assign xfer     = use_lock | pick_any;

  always_comb begin
    grant = pick_grant;
    gid   = pick_id;
    if (use_lock) begin
      grant          = '0;
      grant[lock_id] = 1'b1;
      gid            = lock_id;
    end
  end

  // A full burst drops the hold for one arbitration so RR resumes from the holder
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lock_hold <= 1'b0;
      lock_id   <= '0;
      burst_cnt <= '0;
    end else if (xfer) begin
      lock_hold <= req_lock[gid] && (cnt_next < CNT_W'(MAX_BURST));
      lock_id   <= gid;
      burst_cnt <= cnt_next;
    end else if (lock_hold && !req_valid[lock_id]) begin
      lock_hold <= 1'b0;
      burst_cnt <= '0;
    end
  end
`else
  localparam int unused_max_burst = MAX_BURST;
  logic unused_lock;

  assign unused_lock = ^req_lock;
  assign grant       = pick_grant;
  assign gid         = pick_id;
  assign xfer        = pick_any;
`endif

  assign req_ready = grant;

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // tag_q[RD_LAT] lines up with the cycle bram_rdata is valid for that read
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ptr        <= RST_PTR;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      for (int k = 0; k <= RD_LAT; k++) tag_q[k] <= '0;
    end else begin
      bram_en <= xfer;
      bram_we <= xfer & sel_wr;
      if (xfer) begin
        ptr        <= gid;
        bram_addr  <= sel_addr;
        bram_wdata <= sel_wdata;
      end
      tag_q[0] <= '{vld: xfer & ~sel_wr, id: TAG_ID_W'(gid)};
      for (int k = 1; k <= RD_LAT; k++) tag_q[k] <= tag_q[k-1];
      rsp_valid <= tag_q[RD_LAT].vld ? (NUM_REQ'(1) << tag_q[RD_LAT].id) : '0;
      if (tag_q[RD_LAT].vld) rsp_data <= bram_rdata;
    end
  end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// tb/tb_bram_rr_arbiter.sv - self-checking bench: cycle model of RR/lock/read-return plus directed literals
module tb_bram_rr_arbiter;

  localparam int N    = 4;
  localparam int AW   = 13;
  localparam int DW   = 32;
  localparam int RDL  = 2;
  localparam int MB   = 8;
  localparam int N2   = 2;
  localparam int RDL2 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_wr, req_lock, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_data, bram_wdata, bram_rdata;
  logic            bram_en, bram_we;
  logic [AW-1:0]   bram_addr;

  logic [N2-1:0]    u2_valid, u2_wr, u2_lock, u2_ready, u2_rsp_valid;
  logic [N2*AW-1:0] u2_addr;
  logic [N2*DW-1:0] u2_wdata;
  logic [DW-1:0]    u2_rsp_data, u2_bram_wdata, u2_bram_rdata;
  logic             u2_bram_en, u2_bram_we;
  logic [AW-1:0]    u2_bram_addr;

  bram_rr_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .RD_LAT(RDL), .MAX_BURST(MB)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(req_valid), .req_wr(req_wr),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata));

  bram_rr_arbiter #(.NUM_REQ(N2), .AW(AW), .DW(DW), .RD_LAT(RDL2), .MAX_BURST(MB)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(u2_valid), .req_wr(u2_wr),
    .req_lock(u2_lock), .req_addr(u2_addr), .req_wdata(u2_wdata),
    .req_ready(u2_ready), .rsp_valid(u2_rsp_valid), .rsp_data(u2_rsp_data),
    .bram_en(u2_bram_en), .bram_we(u2_bram_we), .bram_addr(u2_bram_addr),
    .bram_wdata(u2_bram_wdata), .bram_rdata(u2_bram_rdata));

  function automatic logic [DW-1:0] pat(input int a);
    return 32'hC0DE0000 ^ (a * 32'h9E37);
  endfunction

  // BRAM behavioural models; unwritten words read back as pat(addr)
  logic [DW-1:0] b1_mem [int];
  logic [DW-1:0] b1_pipe [RDL];
  logic [DW-1:0] b1_rd;
  always @(posedge clk) begin
    b1_rd = b1_mem.exists(int'(bram_addr)) ? b1_mem[int'(bram_addr)] : pat(int'(bram_addr));
    if (bram_en && bram_we) b1_mem[int'(bram_addr)] = bram_wdata;
    b1_pipe[0] <= b1_rd;
    for (int k = 1; k < RDL; k++) b1_pipe[k] <= b1_pipe[k-1];
  end
  assign bram_rdata = b1_pipe[RDL-1];

  logic [DW-1:0] b2_mem [int];
  logic [DW-1:0] b2_pipe [RDL2];
  logic [DW-1:0] b2_rd;
  always @(posedge clk) begin
    b2_rd = b2_mem.exists(int'(u2_bram_addr)) ? b2_mem[int'(u2_bram_addr)] : pat(int'(u2_bram_addr));
    if (u2_bram_en && u2_bram_we) b2_mem[int'(u2_bram_addr)] = u2_bram_wdata;
    b2_pipe[0] <= b2_rd;
    for (int k = 1; k < RDL2; k++) b2_pipe[k] <= b2_pipe[k-1];
  end
  assign u2_bram_rdata = b2_pipe[RDL2-1];

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: who must win, what the BRAM port must show, which responses are due
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          rq [$];
  logic [DW-1:0] shadow [int];
  int            m_ptr, m_lock, m_run, cyc;
  logic          m_ok = 1'b0;
  logic          exp_en, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;

  function automatic int m_pick();
    if (m_lock >= 0 && req_valid[m_lock]) return m_lock;
    for (int k = 1; k <= N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    int            w;
    logic [N-1:0]  erv;
    logic [DW-1:0] erd;
    logic [AW-1:0] a;
    cyc++;
    if (rst) begin
      m_ok = 1'b1; m_ptr = N - 1; m_lock = -1; m_run = 0;
      rq.delete();
      exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    end else if (m_ok) begin
      check("bram_en", bram_en, exp_en);
      check("bram_we", bram_we, exp_we);
      check("bram_addr", bram_addr, exp_addr);
      check("bram_wdata", bram_wdata, exp_wdata);
      erv = '0; erd = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        erv = N'(1) << rq[0].id;
        erd = rq[0].data;
        void'(rq.pop_front());
      end
      check("rsp_valid", rsp_valid, erv);
      if (erv != 0) check("rsp_data", rsp_data, erd);
      w = m_pick();
      check("req_ready", req_ready, (w >= 0) ? (N'(1) << w) : N'(0));
      if (w >= 0) begin
        a = req_addr[w*AW +: AW];
        exp_en = 1'b1; exp_we = req_wr[w]; exp_addr = a; exp_wdata = req_wdata[w*DW +: DW];
        if (req_wr[w]) shadow[int'(a)] = exp_wdata;
        else rq.push_back('{cyc + 2 + RDL, w,
                             shadow.exists(int'(a)) ? shadow[int'(a)] : pat(int'(a))});
        m_ptr = w;
`ifdef MEM_ARB_LOCK_EN
        m_run  = (w == m_lock) ? m_run + 1 : 1;
        m_lock = (req_lock[w] && m_run < MB) ? w : -1;
`endif
      end else begin
        exp_en = 1'b0; exp_we = 1'b0;
        m_lock = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; u2_valid = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int n5, e;
    rst = 1'b1;
    req_valid = '0; req_wr = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    u2_valid = '0; u2_wr = '0; u2_lock = '0; u2_addr = '0; u2_wdata = '0;
    do_reset();

    // 1: all four reading, grants rotate 0,1,2,3,0
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(16 + i), '0);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 check("t1_grant", req_ready, 4'b0001 << (k % 4));
      tick();
    end
    req_valid = '0;
    repeat (6) tick();

    // 2: requester 2 writes then reads the same word
    set_req(2, 1'b1, 13'h005, 32'hDEADBEEF);
    req_valid = 4'b0100;
    #1 check("t2_wr_ready", req_ready, 4'b0100);
    tick();
    check("t2_bram_we", bram_we, 1'b1);
    check("t2_bram_addr", bram_addr, 13'h005);
    check("t2_bram_wdata", bram_wdata, 32'hDEADBEEF);
    set_req(2, 1'b0, 13'h005, '0);
    tick();
    req_valid = '0;
    repeat (3) tick();
    check("t2_rsp_valid", rsp_valid, 4'b0100);
    check("t2_rsp_data", rsp_data, 32'hDEADBEEF);
    tick();

    // 3: requesters 1 and 3 alternate from ptr=1, requester 0 joins
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(32 + i), '0);
    req_valid = 4'b0010;
    #1 check("t3_prime", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1010;
    #1 check("t3_g3a", req_ready, 4'b1000);
    tick();
    #1 check("t3_g1", req_ready, 4'b0010);
    tick();
    #1 check("t3_g3b", req_ready, 4'b1000);
    tick();
    req_valid = 4'b1011;
    #1 check("t3_g0", req_ready, 4'b0001);
    tick();
    #1 check("t3_g1b", req_ready, 4'b0010);
    tick();
    #1 check("t3_g3c", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    repeat (6) tick();

    // 4: reset right after a read is accepted drops the response
    set_req(0, 1'b0, 13'h007, '0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_bram_en", bram_en, 1'b0);
    check("t4_bram_we", bram_we, 1'b0);
    check("t4_bram_addr", bram_addr, '0);
    check("t4_bram_wdata", bram_wdata, '0);
    check("t4_rsp_valid0", rsp_valid, '0);
    req_valid = 4'b1111;
    #1 check("t4_first_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      check("t4_no_rsp", rsp_valid, '0);
      tick();
    end
    repeat (4) tick();

    // 5: requester 0 locks for 12 beats against requester 1
    do_reset();
    set_req(0, 1'b1, 13'h100, 32'h0000_1111);
    set_req(1, 1'b1, 13'h101, 32'h0000_2222);
    req_lock = 4'b0001;
    req_valid = 4'b0011;
`ifdef MEM_ARB_LOCK_EN
    n5 = 13;
`else
    n5 = 23;
`endif
    for (int k = 0; k < n5; k++) begin
`ifdef MEM_ARB_LOCK_EN
      e = (k == 8) ? 1 : 0;
`else
      e = k % 2;
`endif
      #1 check("t5_grant", req_ready, 4'b0001 << e);
      tick();
    end
    req_valid = '0; req_lock = '0;
    repeat (3) tick();

    // 6: two-port, RD_LAT=1 instance: 16 back-to-back reads, no bubbles
    for (int j = 0; j < 20; j++) begin
      u2_valid = (j < 16) ? 2'b01 : 2'b00;
      u2_addr[AW-1:0] = AW'(j);
      #1 check("t6_ready", u2_ready, (j < 16) ? 2'b01 : 2'b00);
      check("t6_rsp_valid", u2_rsp_valid, (j >= 3 && j < 19) ? 2'b01 : 2'b00);
      if (j >= 3 && j < 19) check("t6_rsp_data", u2_rsp_data, pat(j - 3));
      tick();
    end

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
